fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port empty, input, 1 bit: FIFO empty flag from the upstream fifo.
REQ-005 The block SHALL have port rd_en, output, 1 bit: read request to the upstream fifo.
REQ-006 The block SHALL have port rd_data, input, WIDTH bits: FIFO read data, valid in the cycle after the one in which rd_en was high.
REQ-007 The block SHALL have port out_valid, output, 1 bit: stream data valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: downstream accepts data.
REQ-009 The block SHALL have port out_data, output, WIDTH bits: stream data.
REQ-010 The block SHALL have port xfer_count, output, 16 bits: count of completed stream handshakes.

Function
REQ-011 The block SHALL drain the upstream fifo through its rd_en/rd_data/empty read port and present the words, in FIFO order, on a valid/ready stream.
REQ-012 The block SHALL contain a 2-entry output buffer (occ, 0..2) and a 1-bit in-flight flag (inflight), where inflight is the registered copy of rd_en.
REQ-013 A pop SHALL occur in a cycle where out_valid && out_ready.
REQ-014 rd_en SHALL equal !empty && ((occ + inflight) < 2 || pop), computed combinationally.
REQ-015 rd_en SHALL never be high while empty is high.
REQ-016 When inflight is 1, the block SHALL write rd_data into the buffer tail at the rising edge ending that cycle.
REQ-017 The invariant occ + inflight <= 2 SHALL hold in every cycle; the buffer SHALL never overflow and no read word SHALL ever be dropped.
REQ-018 out_valid SHALL equal (occ != 0), and out_data SHALL be the buffer head; there SHALL be no combinational path from rd_data to out_data.
REQ-019 Latency: with the buffer empty and rd_en high in cycle N, the block SHALL raise out_valid in cycle N+2 with that word.
REQ-020 Throughput: with empty low and out_ready held high, the block SHALL sustain one word per cycle after the initial 2-cycle latency, with no bubbles.
REQ-021 While out_valid is high and out_ready is low, out_valid and out_data SHALL remain stable.
REQ-022 A simultaneous pop and capture SHALL shift the head out and append the new word; occ SHALL be unchanged.
REQ-023 A pop with no capture SHALL decrement occ, and a capture with no pop SHALL increment occ.
REQ-024 xfer_count SHALL increment by 1 on each pop and wrap from 16'hFFFF to 0.
REQ-025 out_ready SHALL have no effect when out_valid is low.

Reset
REQ-026 While rst is low, the block SHALL clear occ, inflight and xfer_count to 0, drive out_valid low, and force rd_en low regardless of empty.
REQ-027 When rst is asserted mid-operation, the block SHALL discard any in-flight or buffered words; the upstream fifo is reset by the same signal.
REQ-028 On the first rising edge after rst goes high, the block SHALL evaluate rd_en normally per REQ-014.

Verification
REQ-029 Scenario -- single word: reset, then empty=0 for one cycle (N) with out_ready=1 -> rd_en=1 in N only; out_valid=1 in N+2 with the written word; xfer_count=1.
REQ-030 Scenario -- streaming: write 20 sequential values 0x00..0x13 into the fifo, hold out_ready=1 -> out_data=0x00..0x13 on 20 consecutive cycles; xfer_count=20.
REQ-031 Scenario -- backpressure: fifo holds 5 words, out_ready=0 -> exactly 2 rd_en pulses occur, then rd_en stays 0 and out_data holds word 0; raise out_ready -> all 5 words arrive in order.
REQ-032 Scenario -- alternating out_ready (1,0,1,0,...) over 50 words -> order preserved, no loss, no duplicates, occ+inflight<=2 assertion never fires.
REQ-033 Scenario -- reset mid-transfer with occ=2, inflight=1 -> out_valid=0 and xfer_count=0 within the reset cycle; after release, rd_en=0 until empty falls.
REQ-034 Scenario -- counter wrap: preload via 65536 handshakes -> xfer_count=0, out_valid behaviour unchanged.
REQ-035 The bench SHALL carry concurrent assertions: rd_en |-> !empty; (out_valid && !out_ready) |=> $stable(out_data) && out_valid; and a tagged in-order data check from fifo write to stream pop.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Drains a first-word-fall-through-less upstream FIFO (1-cycle read latency)
// into a valid/ready stream through a 2-entry skid buffer with in-flight tracking.
module fifo_stream_reader #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             empty,
  output logic             rd_en,
  input  logic [WIDTH-1:0] rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [15:0]      xfer_count
);

  logic [1:0]            occ_reg, occ_next;
  logic                  inflight_reg;
  logic [15:0]           xfer_count_reg;
  logic [1:0][WIDTH-1:0] buf_reg, buf_next;
  logic                  pop;
  logic [1:0]            level;
  logic [1:0]            wr_idx;

  assign out_valid  = (occ_reg != 2'd0);
  assign out_data   = buf_reg[0];
  assign xfer_count = xfer_count_reg;
  assign pop        = out_valid && out_ready;
  assign level      = occ_reg + {1'b0, inflight_reg};

  // A read may be issued into a full pipeline only when a slot frees this cycle.
  assign rd_en  = rst && !empty && ((level < 2'd2) || pop);

  // The returning word lands just behind whatever survives this cycle's pop.
  assign wr_idx = occ_reg - {1'b0, pop};

  always_comb begin
    occ_next = occ_reg;
    case ({inflight_reg, pop})
      2'b10:   occ_next = occ_reg + 2'd1;
      2'b01:   occ_next = occ_reg - 2'd1;
      default: occ_next = occ_reg;
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    logic [WIDTH-1:0] shifted;
    if (gi == 0) begin : g_head
      assign shifted = buf_reg[1];
    end else begin : g_tail
      assign shifted = buf_reg[gi];
    end
    assign buf_next[gi] = (inflight_reg && (wr_idx == 2'(gi))) ? rd_data :
                          (pop ? shifted : buf_reg[gi]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ_reg        <= 2'd0;
      inflight_reg   <= 1'b0;
      xfer_count_reg <= 16'd0;
    end else begin
      occ_reg        <= occ_next;
      inflight_reg   <= rd_en;
      if (pop) xfer_count_reg <= xfer_count_reg + 16'd1;
    end
  end

  // Payload needs no reset: it is only observed while occ is non-zero.
  always_ff @(posedge clk) begin
    buf_reg <= buf_next;
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: queue-based upstream FIFO model,
// expected-word queue filled at write time, independent pop monitor.
module tb_fifo_stream_reader;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             empty = 1'b1;
  logic             rd_en;
  logic [WIDTH-1:0] rd_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [15:0]      xfer_count;

  fifo_stream_reader #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .empty(empty), .rd_en(rd_en), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               tag;
    logic [WIDTH-1:0] data;
  } exp_t;

  int               total = 0;
  int               bad = 0;
  logic [WIDTH-1:0] ufifo[$];
  exp_t             exp_q[$];
  exp_t             exp_e;
  int               next_tag = 0;
  logic [15:0]      model_cnt = 16'd0;
  int               pops_total = 0;
  int               cyc = 0;
  int               pop_cyc[$];
  logic             rd_pending = 1'b0;
  int               rd_pulses = 0;
  bit               verbose = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [WIDTH-1:0] d);
    ufifo.push_back(d);
    exp_q.push_back(exp_t'{tag: next_tag, data: d});
    next_tag++;
    empty = 1'b0;
  endtask

  task automatic drain(input int limit);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    check("drain_done", exp_q.size(), 0);
  endtask

  // Upstream FIFO: a read requested in one cycle returns data early in the next.
  initial forever begin
    @(negedge clk);
    rd_pending = rd_en;
    if (rd_en) rd_pulses++;
    @(posedge clk);
    #1;
    if (rd_pending && rst) begin
      if (ufifo.size() > 0) rd_data = ufifo.pop_front();
      else rd_data = 8'hEE;
    end
    empty = (ufifo.size() == 0);
  end

  // Monitor: compares every handshake against the expected-word queue.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      check("xfer_count", xfer_count, model_cnt);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got %0h want no word", out_data);
        end else begin
          exp_e = exp_q.pop_front();
          check($sformatf("data_tag%0d", exp_e.tag), out_data, exp_e.data);
          if (verbose)
            $display("pop tag=%0d data=%0h want=%0h cnt=%0d", exp_e.tag, out_data, exp_e.data, model_cnt);
        end
        model_cnt = model_cnt + 16'd1;
        pops_total++;
        pop_cyc.push_back(cyc);
      end
    end
  end

  a_rd_empty: assert property (@(posedge clk) disable iff (!rst) rd_en |-> !empty)
    else begin
      bad++;
      $display("FAIL assert_rd_en_empty: rd_en=1 empty=%0b want empty=0", empty);
    end

  a_hold: assert property (@(posedge clk) disable iff (!rst)
                           (out_valid && !out_ready) |=> ($stable(out_data) && out_valid))
    else begin
      bad++;
      $display("FAIL assert_hold: valid=%0b data=%0h want held word", out_valid, out_data);
    end

  a_level: assert property (@(posedge clk) disable iff (!rst)
                            (int'(dut.occ_reg) + int'(dut.inflight_reg)) <= 2)
    else begin
      bad++;
      $display("FAIL assert_level: occ=%0d inflight=%0b want sum<=2", dut.occ_reg, dut.inflight_reg);
    end

  task automatic do_reset();
    rst = 1'b0;
    ufifo.delete();
    exp_q.delete();
    empty = 1'b1;
    model_cnt = 16'd0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  logic [WIDTH-1:0] w [5];
  int c0;
  int pushed;
  int start_pops;
  int n;

  initial begin
    // Reset state, with empty driven low to show rd_en stays gated.
    tick();
    empty = 1'b0;
    @(negedge clk);
    check("reset_rd_en", rd_en, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_xfer_count", xfer_count, 0);
    do_reset();
    tick();
    @(negedge clk);
    check("idle_rd_en", rd_en, 0);

    // Single word: 2-cycle latency.
    out_ready = 1'b1;
    tick();
    push(8'hA5);
    @(negedge clk);
    check("single_rd_en_N", rd_en, 1);
    check("single_valid_N", out_valid, 0);
    tick();
    @(negedge clk);
    check("single_rd_en_N1", rd_en, 0);
    check("single_valid_N1", out_valid, 0);
    tick();
    @(negedge clk);
    check("single_valid_N2", out_valid, 1);
    check("single_data_N2", out_data, 8'hA5);
    tick();
    @(negedge clk);
    check("single_count", xfer_count, 1);
    check("single_valid_after", out_valid, 0);

    // Streaming: 20 words on consecutive cycles.
    tick();
    pop_cyc.delete();
    c0 = cyc;
    for (int i = 0; i < 20; i++) push(WIDTH'(i));
    drain(60);
    check("stream_pops", pop_cyc.size(), 20);
    if (pop_cyc.size() == 20) begin
      check("stream_latency", pop_cyc[0] - c0, 2);
      check("stream_no_bubbles", pop_cyc[19] - pop_cyc[0], 19);
    end
    @(negedge clk);
    check("stream_count", xfer_count, 21);

    // Backpressure: only two reads may be outstanding.
    tick();
    out_ready = 1'b0;
    rd_pulses = 0;
    for (int i = 0; i < 5; i++) begin
      w[i] = WIDTH'($urandom);
      push(w[i]);
    end
    repeat (10) tick();
    @(negedge clk);
    check("bp_rd_pulses", rd_pulses, 2);
    check("bp_rd_en_low", rd_en, 0);
    check("bp_valid", out_valid, 1);
    check("bp_head", out_data, w[0]);
    tick();
    out_ready = 1'b1;
    drain(40);

    // Alternating out_ready over 50 randomly timed words.
    pushed = 0;
    for (int c = 0; c < 600 && (pushed < 50 || exp_q.size() != 0); c++) begin
      tick();
      out_ready = c[0];
      if (pushed < 50 && $urandom_range(1, 0) == 1) begin
        push(WIDTH'($urandom));
        pushed++;
      end
    end
    check("alt_pushed", pushed, 50);
    check("alt_drained", exp_q.size(), 0);

    // Fully random bursts and backpressure.
    for (int c = 0; c < 300; c++) begin
      tick();
      out_ready = ($urandom_range(3, 0) != 0);
      n = $urandom_range(2, 0);
      for (int k = 0; k < n; k++) push(WIDTH'($urandom));
    end
    out_ready = 1'b1;
    drain(2000);

    // Reset mid-transfer with a full buffer.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(WIDTH'($urandom));
    repeat (4) tick();
    @(negedge clk);
    check("pre_reset_valid", out_valid, 1);
    tick();
    rst = 1'b0;
    ufifo.delete();
    exp_q.delete();
    empty = 1'b1;
    model_cnt = 16'd0;
    @(negedge clk);
    check("midreset_valid", out_valid, 0);
    check("midreset_count", xfer_count, 0);
    check("midreset_rd_en", rd_en, 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      check("postreset_rd_en", rd_en, 0);
      check("postreset_valid", out_valid, 0);
    end
    tick();
    out_ready = 1'b1;
    push(8'h3C);
    push(8'hC3);
    drain(20);

    // Counter wrap after 65536 handshakes.
    do_reset();
    verbose = 1'b0;
    out_ready = 1'b1;
    pushed = 0;
    start_pops = pops_total;
    for (int c = 0; c < 70000 && (pushed < 65536 || exp_q.size() != 0); c++) begin
      tick();
      if (pushed < 65536 && ufifo.size() < 4) begin
        push(WIDTH'(pushed));
        pushed++;
      end
    end
    check("wrap_pops", pops_total - start_pops, 65536);
    @(negedge clk);
    check("wrap_count", xfer_count, 0);
    check("wrap_valid_idle", out_valid, 0);
    verbose = 1'b1;
    tick();
    push(8'h5A);
    drain(20);
    @(negedge clk);
    check("wrap_count_after", xfer_count, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
